cache_req_scheduler: RTL and testbench
======================================

Name: cache_req_scheduler

Overview:
- Front-end controller for the 4-way L1/L2 cache system.
- Shares the single cache read port between two requesters, for example the instruction fetch and data load ports, using round-robin arbitration.
- Sequences one request at a time: issue, capture the cache result, then insert a modelled main-memory penalty on double misses.
- Returns the result over a valid/ready response channel and keeps saturating hit/miss statistics.

Parameters:
- ADDR_WIDTH, 11, request/cache address width.
- DATA_WIDTH, 32, read data width.
- MEM_LAT, 4, extra stall cycles on an L1+L2 miss; 0 means no stall. Range 0..255.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a read pending.
- req0_addr  in  ADDR_WIDTH  requester 0 address.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 has a read pending.
- req1_addr  in  ADDR_WIDTH  requester 1 address.
- req1_ready  out  1  requester 1 request accepted this cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester the response belongs to.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_l1_hit  out  1  request hit in L1.
- rsp_l2_hit  out  1  request missed L1 and hit L2.
- cache_read  out  1  read strobe to the cache system.
- cache_addr  out  ADDR_WIDTH  address to the cache system.
- cache_read_data  in  DATA_WIDTH  cache read data, registered, valid the cycle after cache_read.
- cache_l1_hit  in  1  cache L1 hit flag, same timing as cache_read_data.
- cache_l2_hit  in  1  cache L2 hit flag, same timing as cache_read_data.
- cnt_l1_hit  out  CNT_WIDTH  count of L1 hits.
- cnt_l2_hit  out  CNT_WIDTH  count of L2 hits.
- cnt_miss  out  CNT_WIDTH  count of double misses.

Behaviour:
- Reset (asynchronous, any state):
  - Go to IDLE.
  - All registered outputs are 0; cache_read=0; counters=0.
  - last_grant=1, so requester 0 wins the first tie.
  - An in-flight request is dropped with no response.
- FSM states: IDLE, ISSUE, CAPTURE, MISS_WAIT, RESP.
- IDLE:
  - If any reqN_valid, grant one requester.
  - If only one is valid, it is granted.
  - If both are valid, grant the one not equal to last_grant.
  - reqN_ready is combinational, high only in IDLE for the granted requester, in the same cycle as its valid.
  - On that edge, latch addr and id, update last_grant, go to ISSUE.
  - reqN_ready is never high outside IDLE.
- ISSUE (1 cycle):
  - cache_read=1 and cache_addr=latched addr.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Register cache_read_data, cache_l1_hit and cache_l2_hit into the rsp_* holding registers.
  - Increment the matching counter.
  - If either hit flag is set, go to RESP.
  - Otherwise, go to MISS_WAIT with the down-counter loaded to MEM_LAT. If MEM_LAT=0, go directly to RESP.
- MISS_WAIT:
  - Decrement the counter each cycle.
  - Go to RESP in the cycle the counter reaches 1→0. Total stall is exactly MEM_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and the hit flags are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- cache_addr:
  - Holds the latched address in all states.
  - Outside ISSUE it is don't-care, because cache_read=0.
- Latency (no backpressure, req accepted at edge 0):
  - Hit: rsp_valid high after edge 3 (ISSUE 1, CAPTURE 2, RESP from edge 3).
  - Miss: rsp_valid high after edge 3+MEM_LAT.
- Only one request is outstanding. The next ISSUE is at least 2 cycles after CAPTURE, so the cache's L2→L1 promotion write always completes before the next read.
- Counters saturate at all-ones and never wrap.
- Inconsistent input (l1_hit and l2_hit both set): treat as an L1 hit; only cnt_l1_hit increments.
- A requester dropping valid before ready is not an error; no grant is made and last_grant is unchanged.

Test Plan:
- Single request:
  - Stimulus: req0 addr=0x040; cache model returns l1_hit=1, data=0x12345678.
  - Response: req0_ready in the same cycle; cache_read high for exactly 1 cycle, 1 cycle later; rsp_valid 3 cycles after accept with id=0, data=0x12345678, l1=1, l2=0; cnt_l1_hit=1.
- Miss penalty:
  - Stimulus: MEM_LAT=4; model returns no hit, data=0xCAFEBABE.
  - Response: rsp_valid 7 cycles after accept; l1=l2=0; cnt_miss=1.
  - Repeat with MEM_LAT=0: rsp_valid 3 cycles after accept.
- Round-robin:
  - Stimulus: both valid continuously for 4 requests.
  - Response: grants 0,1,0,1; rsp_id sequence matches; no reqN_ready while busy.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP, with an L2 hit, data=0xA5A5A5A5.
  - Response: rsp_valid and all rsp_* stable; no new accept until the handshake; cnt_l2_hit=1.
- Reset mid-operation:
  - Stimulus: assert rst during MISS_WAIT.
  - Response: immediately rsp_valid=0, cache_read=0, counters=0; the next tie grants requester 0.
- Saturation:
  - Stimulus: CNT_WIDTH=2; 5 L1 hits.
  - Response: cnt_l1_hit=3.

Source files
------------

// File: rtl/cache_req_scheduler.sv
// cache_req_scheduler: round-robin front end that issues one cache read at a time, stalls on double misses and returns results over valid/ready
module cache_req_scheduler #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_l1_hit,
  output logic                  rsp_l2_hit,
  output logic                  cache_read,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
  output logic [CNT_WIDTH-1:0]  cnt_l1_hit,
  output logic [CNT_WIDTH-1:0]  cnt_l2_hit,
  output logic [CNT_WIDTH-1:0]  cnt_miss
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, MISS_WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [7:0] wait_q;
  logic id_q, last_grant, l1_q, l2_q, grant0, grant1, inc_l1, inc_l2, inc_miss;
  // grant in IDLE only; on a tie the requester that did not win last time goes
  always_comb begin
    grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  end
  // an L1 hit dominates when the cache reports both flags
  always_comb begin
    inc_l1   = (state == CAPTURE) && cache_l1_hit;
    inc_l2   = (state == CAPTURE) && !cache_l1_hit && cache_l2_hit;
    inc_miss = (state == CAPTURE) && !cache_l1_hit && !cache_l2_hit;
  end
  // next-state sequencing of the single outstanding request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = (grant0 || grant1) ? ISSUE : IDLE;
      ISSUE:     state_nxt = CAPTURE;
      CAPTURE:   state_nxt = (!inc_miss || MEM_LAT == 0) ? RESP : MISS_WAIT;
      MISS_WAIT: state_nxt = (wait_q == 8'd1) ? RESP : MISS_WAIT;
      RESP:      state_nxt = rsp_ready ? IDLE : RESP;
      default:   state_nxt = IDLE;
    endcase
  end
  // state, request latch, response holding registers and miss stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      data_q     <= '0;
      l1_q       <= 1'b0;
      l2_q       <= 1'b0;
      wait_q     <= '0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        addr_q     <= grant1 ? req1_addr : req0_addr;
        id_q       <= grant1;
        last_grant <= grant1;
      end
      if (state == CAPTURE) begin
        data_q <= cache_read_data;
        l1_q   <= cache_l1_hit;
        l2_q   <= inc_l2;
        wait_q <= 8'(MEM_LAT);
      end
      if (state == MISS_WAIT) wait_q <= wait_q - 8'd1;
    end
  end
  // saturating hit/miss statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_l1_hit <= '0;
      cnt_l2_hit <= '0;
      cnt_miss   <= '0;
    end else begin
      if (inc_l1 && !(&cnt_l1_hit)) cnt_l1_hit <= cnt_l1_hit + CNT_WIDTH'(1);
      if (inc_l2 && !(&cnt_l2_hit)) cnt_l2_hit <= cnt_l2_hit + CNT_WIDTH'(1);
      if (inc_miss && !(&cnt_miss)) cnt_miss <= cnt_miss + CNT_WIDTH'(1);
    end
  end
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_l1_hit = l1_q;
  assign rsp_l2_hit = l2_q;
  assign cache_read = (state == ISSUE);
  assign cache_addr = addr_q;
endmodule

// File: tb/tb_cache_req_scheduler.sv
// tb_cache_req_scheduler: scoreboard bench for the cache request scheduler
module tb_cache_req_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [10:0] req0_addr = '0, req1_addr = '0, cache_addr;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_l1_hit, rsp_l2_hit, cache_read;
  logic [31:0] rsp_data, cache_read_data;
  logic cache_l1_hit, cache_l2_hit;
  logic [15:0] cnt_l1_hit, cnt_l2_hit, cnt_miss;

  logic b_req0_valid = 0, b_req1_valid = 0, b_rsp_ready = 1;
  logic [10:0] b_req0_addr = '0, b_req1_addr = '0, b_cache_addr;
  logic b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_l1_hit, b_rsp_l2_hit, b_cache_read;
  logic [31:0] b_rsp_data, b_cache_read_data;
  logic b_cache_l1_hit, b_cache_l2_hit;
  logic [1:0] b_cnt_l1_hit, b_cnt_l2_hit, b_cnt_miss;

  cache_req_scheduler #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_LAT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_l1_hit(rsp_l1_hit), .rsp_l2_hit(rsp_l2_hit),
    .cache_read(cache_read), .cache_addr(cache_addr), .cache_read_data(cache_read_data),
    .cache_l1_hit(cache_l1_hit), .cache_l2_hit(cache_l2_hit),
    .cnt_l1_hit(cnt_l1_hit), .cnt_l2_hit(cnt_l2_hit), .cnt_miss(cnt_miss));

  cache_req_scheduler #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_LAT(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .rsp_l1_hit(b_rsp_l1_hit), .rsp_l2_hit(b_rsp_l2_hit),
    .cache_read(b_cache_read), .cache_addr(b_cache_addr), .cache_read_data(b_cache_read_data),
    .cache_l1_hit(b_cache_l1_hit), .cache_l2_hit(b_cache_l2_hit),
    .cnt_l1_hit(b_cnt_l1_hit), .cnt_l2_hit(b_cnt_l2_hit), .cnt_miss(b_cnt_miss));

  // cache contents by address; region addr[10:9]: 0 L1 hit, 1 L2 hit, 2 double miss, 3 both flags
  function automatic logic [31:0] mdata(logic [10:0] a);
    case (a)
      11'h040: return 32'h12345678;
      11'h480: return 32'hCAFEBABE;
      11'h240: return 32'hA5A5A5A5;
      default: return 32'h5A5A0000 | {21'h0, a};
    endcase
  endfunction
  function automatic logic [1:0] mflags(logic [10:0] a);
    case (a[10:9])
      2'd0: return 2'b10;
      2'd1: return 2'b01;
      2'd2: return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  // registered cache model; outside a read it returns junk so mistimed capture shows up
  always @(posedge clk) begin
    if (cache_read) begin
      cache_read_data <= mdata(cache_addr);
      {cache_l1_hit, cache_l2_hit} <= mflags(cache_addr);
    end else begin
      cache_read_data <= 32'hDEAD0000;
      {cache_l1_hit, cache_l2_hit} <= 2'b00;
    end
    if (b_cache_read) begin
      b_cache_read_data <= mdata(b_cache_addr);
      {b_cache_l1_hit, b_cache_l2_hit} <= mflags(b_cache_addr);
    end else begin
      b_cache_read_data <= 32'hDEAD0000;
      {b_cache_l1_hit, b_cache_l2_hit} <= 2'b00;
    end
  end

  typedef struct {
    logic id;
    logic [10:0] addr;
    logic [31:0] data;
    logic l1, l2;
    int lat, t;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(bit ok, string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(logic id, logic [10:0] a, int lat);
    logic [1:0] f = mflags(a);
    sb.push_back('{id, a, mdata(a), f[1], f[0] & ~f[1], lat, cyc});
  endfunction

  // monitor: checks cache strobe timing, busy grants and every response cycle against the queue head
  initial begin
    bit prev, outstanding;
    int crn;
    exp_t e;
    prev = 0; outstanding = 0; crn = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb.delete();
        prev = 0; outstanding = 0; crn = 0;
        continue;
      end
      if (req0_ready || req1_ready) begin
        chk(!outstanding, "ready_while_busy", 64'(outstanding), 0);
        outstanding = 1;
        crn = 0;
      end
      if (cache_read) begin
        crn++;
        chk(sb.size() != 0, "cache_read_unexpected", 64'(sb.size()), 1);
        if (sb.size() != 0)
          chk(cyc == sb[0].t + 1 && cache_addr == sb[0].addr, "cache_read",
              64'({cache_addr, 32'(cyc - sb[0].t)}), 64'({sb[0].addr, 32'd1}));
      end
      if (rsp_valid) begin
        chk(sb.size() != 0, "rsp_unexpected", 64'(sb.size()), 1);
        if (sb.size() != 0) begin
          e = sb[0];
          if (!prev) chk(cyc - e.t == e.lat, "latency", 64'(cyc - e.t), 64'(e.lat));
          chk({rsp_id, rsp_data, rsp_l1_hit, rsp_l2_hit} == {e.id, e.data, e.l1, e.l2}, "rsp",
              64'({rsp_id, rsp_data, rsp_l1_hit, rsp_l2_hit}), 64'({e.id, e.data, e.l1, e.l2}));
          if (rsp_ready) begin
            chk(crn == 1, "cache_read_count", 64'(crn), 1);
            void'(sb.pop_front());
            outstanding = 0;
          end
        end
      end
      prev = rsp_valid;
    end
  end

  // drive requests; expected grant order follows round robin from 'start'
  task automatic send(bit v0, bit v1, logic [10:0] a0, logic [10:0] a1, bit start, int n, int lat);
    bit exp_id = start;
    int got = 0;
    @(posedge clk); #1;
    req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
    for (int k = 0; k < 200 && got < n; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk(req0_ready != req1_ready && req1_ready == exp_id, "grant",
            64'({req0_ready, req1_ready}), exp_id ? 64'h1 : 64'h2);
        push(exp_id, exp_id ? a1 : a0, lat);
        if (v0 && v1) exp_id = !exp_id;
        got++;
      end
    end
    chk(got == n, "grant_count", 64'(got), 64'(n));
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic b_req(logic [10:0] a, int lat, logic [31:0] d);
    int t0 = 0, k = 0;
    @(posedge clk); #1;
    b_req0_valid = 1; b_req0_addr = a;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_req0_ready) break;
    end
    chk(k < 20, "b_accept_timeout", 64'(k), 0);
    t0 = cyc;
    @(posedge clk); #1;
    b_req0_valid = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_rsp_valid) break;
    end
    chk(cyc - t0 == lat && b_rsp_data == d, "b_rsp", 64'({32'(cyc - t0), b_rsp_data}), 64'({32'(lat), d}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(!rsp_valid && !cache_read && !req0_ready && {cnt_l1_hit, cnt_l2_hit, cnt_miss} == 0, "reset_state",
        64'({rsp_valid, cache_read, req0_ready, cnt_l1_hit, cnt_l2_hit, cnt_miss}), 0);
    #1 rst = 0;
    // single L1 hit
    send(1, 0, 11'h040, 11'h0, 0, 1, 3);
    drain();
    chk(cnt_l1_hit == 1, "cnt_l1_single", 64'(cnt_l1_hit), 1);
    // double miss with a 4-cycle memory penalty
    send(1, 0, 11'h480, 11'h0, 0, 1, 7);
    drain();
    chk(cnt_miss == 1, "cnt_miss", 64'(cnt_miss), 1);
    // L2 hit held under backpressure while requester 0 waits
    rsp_ready = 0;
    send(0, 1, 11'h0, 11'h240, 1, 1, 3);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    req0_valid = 1; req0_addr = 11'h041;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0;
    rsp_ready = 1;
    drain();
    chk(cnt_l2_hit == 1, "cnt_l2_backpressure", 64'(cnt_l2_hit), 1);
    // both requesters continuously valid
    send(1, 1, 11'h041, 11'h242, 0, 4, 3);
    drain();
    chk(cnt_l1_hit == 3 && cnt_l2_hit == 3 && cnt_miss == 1, "cnt_after_rr",
        64'({cnt_l1_hit, cnt_l2_hit, cnt_miss}), 64'({16'd3, 16'd3, 16'd1}));
    // both hit flags counts as L1 only
    send(1, 0, 11'h600, 11'h0, 0, 1, 3);
    drain();
    chk(cnt_l1_hit == 4 && cnt_l2_hit == 3, "cnt_both_flags", 64'({cnt_l1_hit, cnt_l2_hit}), 64'({16'd4, 16'd3}));
    // reset while stalled on a miss
    send(1, 0, 11'h481, 11'h0, 0, 1, 7);
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    chk(!rsp_valid && !cache_read && {cnt_l1_hit, cnt_l2_hit, cnt_miss} == 0, "async_reset",
        64'({rsp_valid, cache_read, cnt_l1_hit, cnt_l2_hit, cnt_miss}), 0);
    @(posedge clk);
    @(negedge clk);
    #3 rst = 0;
    send(1, 1, 11'h041, 11'h242, 0, 1, 3);
    drain();
    chk(cnt_l1_hit == 1 && cnt_miss == 0, "cnt_after_reset", 64'({cnt_l1_hit, cnt_miss}), 64'({16'd1, 16'd0}));
    // zero memory latency and 2-bit saturating counters
    b_req(11'h480, 3, 32'hCAFEBABE);
    chk(b_cnt_miss == 1, "b_cnt_miss", 64'(b_cnt_miss), 1);
    for (int i = 0; i < 5; i++) b_req(11'h040, 3, 32'h12345678);
    chk(b_cnt_l1_hit == 3, "b_cnt_saturate", 64'(b_cnt_l1_hit), 3);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
